// File: rtl/risc_fetch_queue.sv
// rtl/risc_fetch_queue.sv - in-order instruction fetch queue with branch redirect and wrong-path discard
// Optional FETCH_BYPASS_EN: a response arriving at an empty queue drives the decode outputs in the same cycle.
module risc_fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  input  logic        stall_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ready_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  output logic [31:0] instr_o,
  output logic [31:0] pc_o,
  output logic [31:0] pc_plus4_o,
  output logic        valid_o
);

  localparam int          AW      = $clog2(DEPTH);
  localparam int          CW      = AW + 1;
  localparam logic [31:0] NOP     = 32'h0000_0013;
  localparam logic [CW:0] DEPTH_W = (CW + 1)'(DEPTH);

  logic [31:0]   fpc_q, fpc_d;
  logic [31:0]   rpc_q, rpc_d;
  logic [CW-1:0] occ_q, occ_d;
  logic [CW-1:0] out_q, out_d;
  logic [CW-1:0] drop_q, drop_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;

  logic [31:0] fifo_instr_q [DEPTH];
  logic [31:0] fifo_pc_q    [DEPTH];

  logic [CW:0] inflight;
  logic        issue;
  logic        rsp_accept;
  logic        rsp_keep;
  logic        head_valid;
  logic        byp_valid;
  logic        byp_take;
  logic        push;
  logic        pop;

  // Credits cover both buffered and in-flight words, so a response always has a free slot.
  assign inflight   = {1'b0, occ_q} + {1'b0, out_q};
  assign imem_req_o = rst && !redirect_i && (inflight < DEPTH_W);
  assign imem_addr_o = fpc_q;
  assign issue      = imem_req_o && imem_ready_i;
  assign rsp_accept = imem_rvalid_i && (out_q != '0);
  assign rsp_keep   = rsp_accept && (drop_q == '0) && !redirect_i;
  assign head_valid = (occ_q != '0);

`ifdef FETCH_BYPASS_EN
  assign byp_valid = rsp_keep && !head_valid;
`else
  assign byp_valid = 1'b0;
`endif

  assign byp_take = byp_valid && !stall_i;
  assign pop      = head_valid && !stall_i && !redirect_i;
  assign push     = rsp_keep && !byp_take;

  always_comb begin
    fpc_d    = fpc_q;
    rpc_d    = rpc_q;
    occ_d    = occ_q;
    drop_d   = drop_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    out_d    = out_q + CW'(issue) - CW'(rsp_accept);

    if (redirect_i) begin
      // Everything still in flight belongs to the wrong path, except a response retiring this cycle.
      fpc_d    = redirect_pc_i;
      rpc_d    = redirect_pc_i;
      occ_d    = '0;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      drop_d   = out_q - CW'(rsp_accept);
    end else begin
      if (issue)
        fpc_d = fpc_q + 32'd4;
      if (rsp_accept && (drop_q != '0))
        drop_d = drop_q - CW'(1);
      if (rsp_keep)
        rpc_d = rpc_q + 32'd4;
      if (push)
        wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)
        rd_ptr_d = rd_ptr_q + AW'(1);
      occ_d = occ_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fpc_q    <= RESET_PC;
      rpc_q    <= RESET_PC;
      occ_q    <= '0;
      out_q    <= '0;
      drop_q   <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
    end else begin
      fpc_q    <= fpc_d;
      rpc_q    <= rpc_d;
      occ_q    <= occ_d;
      out_q    <= out_d;
      drop_q   <= drop_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_instr_q[wr_ptr_q] <= imem_rdata_i;
      fifo_pc_q[wr_ptr_q]    <= rpc_q;
    end
  end

  always_comb begin
    valid_o    = head_valid || byp_valid;
    instr_o    = NOP;
    pc_o       = 32'h0;
    pc_plus4_o = 32'h0;
    if (head_valid) begin
      instr_o    = fifo_instr_q[rd_ptr_q];
      pc_o       = fifo_pc_q[rd_ptr_q];
      pc_plus4_o = fifo_pc_q[rd_ptr_q] + 32'd4;
    end else if (byp_valid) begin
      instr_o    = imem_rdata_i;
      pc_o       = rpc_q;
      pc_plus4_o = rpc_q + 32'd4;
    end
  end

endmodule

// File: tb/tb_risc_fetch_queue.sv
// tb/tb_risc_fetch_queue.sv - directed bench for risc_fetch_queue with a variable-latency in-order memory model
module tb_risc_fetch_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        stall_i;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_ready_i;
  logic        imem_rvalid_i;
  logic [31:0] imem_rdata_i;
  logic [31:0] instr_o;
  logic [31:0] pc_o;
  logic [31:0] pc_plus4_o;
  logic        valid_o;

  always #5 clk = ~clk;

  risc_fetch_queue #(.DEPTH(4), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst(rst), .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
    .stall_i(stall_i), .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o),
    .imem_ready_i(imem_ready_i), .imem_rvalid_i(imem_rvalid_i), .imem_rdata_i(imem_rdata_i),
    .instr_o(instr_o), .pc_o(pc_o), .pc_plus4_o(pc_plus4_o), .valid_o(valid_o)
  );

`ifdef FETCH_BYPASS_EN
  localparam int BYP = 1;
`else
  localparam int BYP = 0;
`endif
  localparam logic [31:0] NOP = 32'h0000_0013;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int lat      = 1;
  bit stray    = 1'b0;
  logic [31:0] pend_addr [$];
  int          pend_due  [$];

  logic        s_req, s_valid;
  logic [31:0] s_addr, s_instr, s_pc, s_pc4;

  function automatic logic [31:0] memw(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  // One clock cycle: drive memory response, settle, snapshot outputs, record handshakes, advance.
  task automatic step();
    if (stray) begin
      imem_rvalid_i = 1'b1;
      imem_rdata_i  = 32'hDEAD_BEEF;
    end else if (pend_addr.size() > 0 && pend_due[0] <= cyc) begin
      imem_rvalid_i = 1'b1;
      imem_rdata_i  = memw(pend_addr[0]);
    end else begin
      imem_rvalid_i = 1'b0;
      imem_rdata_i  = 32'h0;
    end
    #1;
    s_req = imem_req_o; s_addr = imem_addr_o; s_valid = valid_o;
    s_instr = instr_o; s_pc = pc_o; s_pc4 = pc_plus4_o;
    if (rst && imem_req_o && imem_ready_i) begin
      pend_addr.push_back(imem_addr_o);
      pend_due.push_back(cyc + lat);
    end
    if (imem_rvalid_i && !stray) begin
      pend_addr.delete(0);
      pend_due.delete(0);
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b0; redirect_i = 1'b0; redirect_pc_i = 32'h0; stall_i = 1'b0;
    imem_ready_i = 1'b1; stray = 1'b0;
    pend_addr.delete(); pend_due.delete();
    step(); step();
    rst = 1'b1;
    cyc = 0;
  endtask

  task automatic test_reset();
    rst = 1'b0; redirect_i = 1'b0; redirect_pc_i = 32'h0; stall_i = 1'b0; imem_ready_i = 1'b1;
    step();
    n_checks++; if (s_valid !== 1'b0) $display("FAIL rst_valid got %b want 0", s_valid); else n_pass++;
    n_checks++; if (s_instr !== NOP) $display("FAIL rst_instr got %h want %h", s_instr, NOP); else n_pass++;
    n_checks++; if (s_pc !== 32'h0) $display("FAIL rst_pc got %h want 0", s_pc); else n_pass++;
    n_checks++; if (s_pc4 !== 32'h0) $display("FAIL rst_pc4 got %h want 0", s_pc4); else n_pass++;
    n_checks++; if (s_req !== 1'b0) $display("FAIL rst_req got %b want 0", s_req); else n_pass++;
  endtask

  task automatic test_stream();
    int first;
    first = 2 - BYP;
    do_reset(); lat = 1;
    for (int c = 0; c <= first + 2; c++) begin
      step();
      n_checks++;
      if (s_req !== 1'b1 || s_addr !== 32'(4 * c))
        $display("FAIL stream_addr c%0d got req=%b addr=%h want req=1 addr=%h", c, s_req, s_addr, 32'(4 * c));
      else n_pass++;
      n_checks++;
      if (s_valid !== (c >= first)) $display("FAIL stream_valid c%0d got %b want %b", c, s_valid, c >= first);
      else n_pass++;
      if (c >= first) begin
        n_checks++;
        if (s_pc !== 32'(4 * (c - first)) || s_instr !== memw(32'(4 * (c - first))) || s_pc4 !== 32'(4 * (c - first) + 4))
          $display("FAIL stream_head c%0d got pc=%h instr=%h pc4=%h want pc=%h", c, s_pc, s_instr, s_pc4, 32'(4 * (c - first)));
        else n_pass++;
      end
    end
  endtask

  task automatic test_stall();
    logic [31:0] exp_pc;
    do_reset(); lat = 1; exp_pc = 32'h0;
    for (int c = 0; c < 4; c++) begin
      step();
      if (s_valid) begin
        n_checks++;
        if (s_pc !== exp_pc) $display("FAIL stall_pre pc got %h want %h", s_pc, exp_pc); else n_pass++;
        exp_pc += 4;
      end
    end
    stall_i = 1'b1;
    for (int c = 0; c < 6; c++) begin
      step();
      n_checks++;
      if (s_valid !== 1'b1 || s_pc !== exp_pc)
        $display("FAIL stall_hold c%0d got valid=%b pc=%h want valid=1 pc=%h", c, s_valid, s_pc, exp_pc);
      else n_pass++;
    end
    n_checks++; if (s_req !== 1'b0) $display("FAIL stall_full_req got %b want 0", s_req); else n_pass++;
    stall_i = 1'b0;
    for (int c = 0; c < 8; c++) begin
      step();
      n_checks++;
      if (s_valid !== 1'b1 || s_pc !== exp_pc || s_instr !== memw(exp_pc))
        $display("FAIL stall_resume c%0d got valid=%b pc=%h instr=%h want pc=%h", c, s_valid, s_pc, s_instr, exp_pc);
      else n_pass++;
      exp_pc += 4;
    end
  endtask

  task automatic test_redirect();
    bit seen;
    do_reset(); lat = 3;
    step(); step();
    redirect_i = 1'b1; redirect_pc_i = 32'h0000_0100;
    step();
    redirect_i = 1'b0;
    n_checks++; if (s_req !== 1'b0) $display("FAIL redir_req got %b want 0", s_req); else n_pass++;
    seen = 1'b0;
    for (int c = 3; c < 16 && !seen; c++) begin
      step();
      if (c == 3) begin
        n_checks++;
        if (s_req !== 1'b1 || s_addr !== 32'h100) $display("FAIL redir_addr got req=%b addr=%h want 100", s_req, s_addr);
        else n_pass++;
      end
      if (s_valid) begin
        seen = 1'b1;
        n_checks++;
        if (c != 7 - BYP) $display("FAIL redir_latency got cycle %0d want %0d", c, 7 - BYP); else n_pass++;
        n_checks++;
        if (s_pc !== 32'h100 || s_instr !== memw(32'h100))
          $display("FAIL redir_head got pc=%h instr=%h want pc=100 instr=%h", s_pc, s_instr, memw(32'h100));
        else n_pass++;
      end
    end
    if (!seen) begin n_checks++; $display("FAIL redir_timeout got no valid want valid"); end
  endtask

  task automatic test_redirect_pop();
    bit seen;
    do_reset(); lat = 1;
    step(); step();
    redirect_i = 1'b1; redirect_pc_i = 32'h0000_0200;
    step();
    redirect_i = 1'b0;
    n_checks++; if (s_req !== 1'b0) $display("FAIL rpop_req got %b want 0", s_req); else n_pass++;
    step();
    n_checks++; if (s_valid !== 1'b0) $display("FAIL rpop_empty got valid=%b want 0", s_valid); else n_pass++;
    n_checks++;
    if (s_req !== 1'b1 || s_addr !== 32'h200) $display("FAIL rpop_fpc got req=%b addr=%h want 200", s_req, s_addr);
    else n_pass++;
    seen = 1'b0;
    for (int c = 4; c < 12 && !seen; c++) begin
      step();
      if (s_valid) begin
        seen = 1'b1;
        n_checks++;
        if (c != 5 - BYP || s_pc !== 32'h200 || s_instr !== memw(32'h200))
          $display("FAIL rpop_head got cycle=%0d pc=%h instr=%h want cycle=%0d pc=200", c, s_pc, s_instr, 5 - BYP);
        else n_pass++;
      end
    end
    if (!seen) begin n_checks++; $display("FAIL rpop_timeout got no valid want valid"); end
  endtask

  task automatic test_reset_mid();
    bit seen;
    do_reset(); lat = 3;
    step(); step();
    rst = 1'b0;
    pend_addr.delete(); pend_due.delete();
    step();
    n_checks++; if (s_valid !== 1'b0) $display("FAIL midrst_valid got %b want 0", s_valid); else n_pass++;
    n_checks++; if (s_instr !== NOP) $display("FAIL midrst_instr got %h want %h", s_instr, NOP); else n_pass++;
    n_checks++; if (s_pc !== 32'h0 || s_pc4 !== 32'h0) $display("FAIL midrst_pc got %h/%h want 0/0", s_pc, s_pc4); else n_pass++;
    n_checks++; if (s_req !== 1'b0) $display("FAIL midrst_req got %b want 0", s_req); else n_pass++;
    step();
    rst = 1'b1; cyc = 0; stray = 1'b1;
    step();
    stray = 1'b0;
    n_checks++; if (s_valid !== 1'b0) $display("FAIL stray_valid got %b want 0", s_valid); else n_pass++;
    n_checks++;
    if (s_req !== 1'b1 || s_addr !== 32'h0) $display("FAIL restart_addr got req=%b addr=%h want 0", s_req, s_addr);
    else n_pass++;
    seen = 1'b0;
    for (int c = 1; c < 12 && !seen; c++) begin
      step();
      if (s_valid) begin
        seen = 1'b1;
        n_checks++;
        if (s_pc !== 32'h0 || s_instr !== memw(32'h0))
          $display("FAIL restart_head got pc=%h instr=%h want pc=0 instr=%h", s_pc, s_instr, memw(32'h0));
        else n_pass++;
      end
    end
    if (!seen) begin n_checks++; $display("FAIL restart_timeout got no valid want valid"); end
  endtask

  task automatic test_wrap();
    logic [31:0] exp_pc, exp_addr;
    int npop;
    do_reset(); lat = 2;
    redirect_i = 1'b1; redirect_pc_i = 32'hFFFF_FFF4;
    step();
    redirect_i = 1'b0;
    exp_pc = 32'hFFFF_FFF4; exp_addr = 32'hFFFF_FFF4; npop = 0;
    for (int c = 0; c < 60; c++) begin
      imem_ready_i = 1'($urandom_range(0, 1));
      step();
      if (s_req && imem_ready_i) begin
        n_checks++;
        if (s_addr !== exp_addr) $display("FAIL wrap_addr got %h want %h", s_addr, exp_addr); else n_pass++;
        exp_addr += 4;
      end
      if (s_valid) begin
        n_checks++;
        if (s_pc !== exp_pc || s_instr !== memw(exp_pc) || s_pc4 !== exp_pc + 32'd4)
          $display("FAIL wrap_head got pc=%h instr=%h pc4=%h want pc=%h", s_pc, s_instr, s_pc4, exp_pc);
        else n_pass++;
        exp_pc += 4;
        npop++;
      end
    end
    imem_ready_i = 1'b1;
    n_checks++; if (npop < 8) $display("FAIL wrap_progress got %0d pops want >=8", npop); else n_pass++;
  endtask

  initial begin
    rst = 1'b0; redirect_i = 1'b0; redirect_pc_i = 32'h0; stall_i = 1'b0;
    imem_ready_i = 1'b1; imem_rvalid_i = 1'b0; imem_rdata_i = 32'h0;
    @(negedge clk);
    test_reset();
    test_stream();
    test_stall();
    test_redirect();
    test_redirect_pop();
    test_reset_mid();
    test_wrap();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
